div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port Start  input  1  launches a division; sampled only in IDLE.
REQ-005 The block SHALL have port Signed  input  1  1 = SDIV semantics, 0 = UDIV; sampled with Start.
REQ-006 The block SHALL have port SrcA  input  WIDTH  dividend; sampled with Start.
REQ-007 The block SHALL have port SrcB  input  WIDTH  divisor; sampled with Start.
REQ-008 The block SHALL have port Busy  output  1  high while a division is in progress (RUN, FIX).
REQ-009 The block SHALL have port Done  output  1  single-cycle pulse; results valid.
REQ-010 The block SHALL have port Quotient  output  WIDTH  registered quotient.
REQ-011 The block SHALL have port Remainder  output  WIDTH  registered remainder.
REQ-012 The block SHALL have port DivByZero  output  1  registered; set when the sampled SrcB was zero.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-014 IDLE with Start=1 and SrcB!=0: the block SHALL capture operand magnitudes and the signs, clear the iteration counter, and go to RUN at edge E0.
REQ-015 IDLE with Start=1 and SrcB==0: the block SHALL go directly to DONE at E0 with Quotient=0, Remainder=SrcA and DivByZero=1 (Done high in the cycle after E0).
REQ-016 RUN SHALL perform one radix-2 restoring step per edge, MSB first, for exactly WIDTH edges (E1..E32 for WIDTH=32), then go to FIX.
REQ-017 FIX SHALL apply the signs, register Quotient, Remainder and DivByZero=0, and go to DONE at E33; Done SHALL be high for exactly the one cycle following E33.
REQ-018 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019 Results SHALL hold their values until the next accepted Start or reset.
REQ-020 In signed mode, the quotient SHALL be negated iff the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield Quotient=0x80000000 and Remainder=0 without any flag.
REQ-022 In unsigned mode, operands SHALL be treated as raw magnitudes and no sign fix SHALL be applied.
REQ-023 Start asserted in RUN, FIX or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 Busy SHALL be low in IDLE and DONE, so a new Start is accepted in the cycle after Done.

Reset
REQ-025 While reset is high, the state SHALL be IDLE and Busy, Done, DivByZero, Quotient, Remainder and the counter SHALL all be 0, independent of clk.
REQ-026 Reset during RUN or FIX SHALL abort the operation with no Done pulse; the block SHALL accept Start on the first edge after reset deasserts.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, RUN, FIX, DONE), the default WIDTH, and the DIV_LATENCY=33 constant.
REQ-028 One combinational sub-module, div_step, SHALL implement a single shift-compare-subtract iteration, taking the partial remainder, the next dividend bit and the divisor, and producing the new remainder and quotient bit.

Verification
REQ-029 Unsigned 100/7 -> Quotient=14, Remainder=2, Done exactly 33 edges after the Start edge, Busy high throughout.
REQ-030 Signed -7/2 (0xFFFFFFF9/2) -> Quotient=0xFFFFFFFD, Remainder=0xFFFFFFFF; unsigned on the same bits -> Quotient=0x7FFFFFFC, Remainder=1.
REQ-031 5/0 -> Quotient=0, Remainder=5, DivByZero=1, Done in the cycle after the Start edge.
REQ-032 0x80000000/0xFFFFFFFF -> signed: Quotient=0x80000000, Remainder=0; unsigned: Quotient=0, Remainder=0x80000000.
REQ-033 Reset pulsed at RUN iteration 10 -> all outputs 0 with no Done; a following 9/3 -> Quotient=3, Remainder=0.
REQ-034 Start re-asserted with 50/5 during RUN of 100/7 -> ignored; only 14 and 2 are reported, with one Done pulse.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider.
// Holds the controller state encoding, the default operand width, the
// Start-to-result latency, and a helper that decodes which states count as busy.
package div_unit_pkg;

  // Default operand/result width in bits.
  localparam int DIV_WIDTH = 32;

  // Edges from the Start edge to the edge that registers the results.
  localparam int DIV_LATENCY = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Busy covers the iterating and sign-fix states only.
  function automatic logic is_busy_state(input state_t st);
    logic busy_s;
    case (st)
      RUN:     busy_s = 1'b1;
      FIX:     busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
    return busy_s;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// Single radix-2 restoring division step (purely combinational).
// Ports:
//   rem_in  - current partial remainder (always < divisor)
//   dvd_bit - next dividend bit, MSB first
//   divisor - divisor magnitude
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift in the next dividend bit, trial-subtract, and restore if negative.
  // Because rem_in < divisor, the shifted value is below 2*divisor, so a clear
  // top bit of the difference means the subtraction succeeded.
  always_comb begin
    shifted_s = {rem_in, dvd_bit};
    diff_s    = shifted_s - {1'b0, divisor};
    if (diff_s[WIDTH] == 1'b0) begin
      rem_out = diff_s[WIDTH-1:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted_s[WIDTH-1:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider.
// A division is launched by Start in IDLE. It takes WIDTH restoring steps in
// RUN, then one sign-fix cycle in FIX, then a single DONE cycle with Done high.
// A zero divisor skips straight to DONE.
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   Start, Signed         - launch request and signed-mode select (sampled in IDLE)
//   SrcA, SrcB            - dividend and divisor (sampled with Start)
//   Busy, Done            - in-progress flag and one-cycle result-valid pulse
//   Quotient, Remainder   - registered results, held until the next accepted Start
//   DivByZero             - registered flag for a zero divisor
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   dvd_r;       // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0]   dsr_r;
  logic [WIDTH-1:0]   rem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic [WIDTH-1:0]   rem_next_s;
  logic               q_bit_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic               b_zero_s;

  // Operand conditioning: signs and magnitudes of the live inputs.
  // The most negative value negates to itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    a_neg_s  = Signed & SrcA[WIDTH-1];
    b_neg_s  = Signed & SrcB[WIDTH-1];
    a_mag_s  = a_neg_s ? ({WIDTH{1'b0}} - SrcA) : SrcA;
    b_mag_s  = b_neg_s ? ({WIDTH{1'b0}} - SrcB) : SrcB;
    b_zero_s = (SrcB == {WIDTH{1'b0}});
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvd_bit (dvd_r[WIDTH-1]),
    .divisor (dsr_r),
    .rem_out (rem_next_s),
    .q_bit   (q_bit_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; Start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (Start) begin
          if (b_zero_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_STEP) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered status outputs, decoded from the upcoming state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Busy <= is_busy_state(state_s);
      Done <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration, and sign fix of the results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_r     <= {WIDTH{1'b0}};
      dsr_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      Quotient  <= {WIDTH{1'b0}};
      Remainder <= {WIDTH{1'b0}};
      DivByZero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            if (b_zero_s) begin
              Quotient  <= {WIDTH{1'b0}};
              Remainder <= SrcA;
              DivByZero <= 1'b1;
            end else begin
              dvd_r   <= a_mag_s;
              dsr_r   <= b_mag_s;
              rem_r   <= {WIDTH{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
              neg_q_r <= a_neg_s ^ b_neg_s;
              neg_r_r <= a_neg_s;
            end
          end
        end
        RUN: begin
          dvd_r <= {dvd_r[WIDTH-2:0], q_bit_s};
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          Quotient  <= neg_q_r ? ({WIDTH{1'b0}} - dvd_r) : dvd_r;
          Remainder <= neg_r_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
          DivByZero <= 1'b0;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule
